// File: rtl/game_pkg.sv
// Shared constants and types for the per-player game control blocks.
package game_pkg;
   localparam int HP_W        = 7;
   localparam int EN_W        = 6;
   localparam int HP_MAX      = 100;
   localparam int DMG_FULL    = 10;
   localparam int DMG_SHIELD  = 2;
   localparam int IFRAMES     = 30;
   localparam int BLINK_SHIFT = 2;
   localparam int EN_MAX      = 63;
   localparam int EN_REGEN    = 8;

   typedef enum logic [1:0] {ALIVE = 2'd0, HURT = 2'd1, DEAD = 2'd2} hp_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/shield_energy.sv
// Shield energy store: drains while defending, regenerates one unit every EN_REGEN idle cycles.
// shield_on is combinational from the registered energy; everything else updates one cycle later.
module shield_energy #(
   parameter int EN_MAX   = game_pkg::EN_MAX,
   parameter int EN_REGEN = game_pkg::EN_REGEN
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      restart,
   input  logic                      defend,
   input  logic                      dead_i,
   output logic [game_pkg::EN_W-1:0] energy,
   output logic                      shield_on
);
   import game_pkg::*;

   localparam int RG_W = cnt_w(EN_REGEN);

   logic [RG_W-1:0] regen_cnt;

   assign shield_on = defend && (energy != '0) && !dead_i;

   // A held defend with empty energy still blocks regeneration until it is released.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         energy    <= EN_W'(EN_MAX);
         regen_cnt <= '0;
      end else if (!dead_i) begin
         if (defend) begin
            regen_cnt <= '0;
            if (energy != '0)
               energy <= energy - 1'b1;
         end else if (regen_cnt == RG_W'(EN_REGEN - 1)) begin
            regen_cnt <= '0;
            if (energy != EN_W'(EN_MAX))
               energy <= energy + 1'b1;
         end else begin
            regen_cnt <= regen_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/hp_ctrl.sv
// Per-player health controller: applies hit damage (reduced under shield), runs i-frames, signals KO.
// Hit to hp/state change is one cycle; restart or rst returns the player to full health.
module hp_ctrl #(
   parameter int HP_MAX      = game_pkg::HP_MAX,
   parameter int DMG_FULL    = game_pkg::DMG_FULL,
   parameter int DMG_SHIELD  = game_pkg::DMG_SHIELD,
   parameter int IFRAMES     = game_pkg::IFRAMES,
   parameter int BLINK_SHIFT = game_pkg::BLINK_SHIFT,
   parameter int EN_MAX      = game_pkg::EN_MAX,
   parameter int EN_REGEN    = game_pkg::EN_REGEN
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      hit,
   input  logic                      defend,
   input  logic                      restart,
   output logic [game_pkg::HP_W-1:0] hp,
   output logic                      shield_on,
   output logic [game_pkg::EN_W-1:0] energy,
   output logic                      invincible,
   output logic                      blink,
   output logic                      dead,
   output logic                      dmg_taken
);
   import game_pkg::*;

   localparam int IF_W = cnt_w(IFRAMES);

   hp_state_t       state, state_nxt;
   logic [HP_W-1:0] hp_nxt, dmg;
   logic [IF_W-1:0] ifr_cnt, ifr_nxt;
   logic            dmg_nxt;
   logic            is_dead;

   assign is_dead    = (state == DEAD);
   assign dead       = is_dead;
   assign invincible = (state == HURT);

   shield_energy #(
      .EN_MAX   (EN_MAX),
      .EN_REGEN (EN_REGEN)
   ) u_shield (
      .clk       (clk),
      .rst       (rst),
      .restart   (restart),
      .defend    (defend),
      .dead_i    (is_dead),
      .energy    (energy),
      .shield_on (shield_on)
   );

   always_comb begin
      state_nxt = state;
      hp_nxt    = hp;
      ifr_nxt   = ifr_cnt;
      dmg       = shield_on ? HP_W'(DMG_SHIELD) : HP_W'(DMG_FULL);
      case (state)
         ALIVE: begin
            if (hit) begin
               hp_nxt = (hp > dmg) ? hp - dmg : '0;
               if (hp_nxt == '0) begin
                  state_nxt = DEAD;
               end else begin
                  state_nxt = HURT;
                  ifr_nxt   = IF_W'(IFRAMES - 1);
               end
            end
         end
         HURT: begin
            if (ifr_cnt == '0)
               state_nxt = ALIVE;
            else
               ifr_nxt = ifr_cnt - 1'b1;
         end
         DEAD:    hp_nxt = '0;
         default: state_nxt = ALIVE;
      endcase
      dmg_nxt = (hp_nxt != hp);
   end

   // Blink is registered from the next counter value so it tracks the live counter bit.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         state     <= ALIVE;
         hp        <= HP_W'(HP_MAX);
         ifr_cnt   <= '0;
         dmg_taken <= 1'b0;
         blink     <= 1'b0;
      end else begin
         state     <= state_nxt;
         hp        <= hp_nxt;
         ifr_cnt   <= ifr_nxt;
         dmg_taken <= dmg_nxt;
         blink     <= (state_nxt == HURT) ? ifr_nxt[BLINK_SHIFT] : 1'b0;
      end
   end
endmodule
